// File: rtl/bus_definitions_pkg.sv
// Shared bus datapath definitions: default FIFO geometry and the one-hot operation FSM encoding.
package bus_definitions;

  localparam VERSION = "0.2";

  localparam int ws    = 4;
  localparam int depth = 8;
  localparam int as    = $clog2(depth);

  typedef enum logic [1:0] {
    IDLE_B    = 2'd0,
    INSERT_B  = 2'd1,
    REMOVE_B  = 2'd2,
    INS_REM_B = 2'd3
  } fifo_state_bit_t;

  typedef enum logic [3:0] {
    IDLE          = 4'b0001,
    INSERT        = 4'b0010,
    REMOVE        = 4'b0100,
    INSERT_REMOVE = 4'b1000
  } fifo_fsm_states_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  function automatic fifo_fsm_states_t op_state(input logic push_ok, input logic pop_ok);
    fifo_fsm_states_t s;
    case ({push_ok, pop_ok})
      2'b01:   s = REMOVE;
      2'b10:   s = INSERT;
      2'b11:   s = INSERT_REMOVE;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WS storage with one write port and a registered read port; storage itself is never reset.
module fifo_regfile import bus_definitions::*; #(
  parameter int WS    = ws,
  parameter int DEPTH = depth,
  parameter int AS    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AS-1:0] waddr,
  input  logic [WS-1:0] wdata,
  input  logic          re,
  input  logic [AS-1:0] raddr,
  output logic [WS-1:0] rdata
);

  logic [WS-1:0] mem_q [DEPTH];
  logic [WS-1:0] rdata_q;

  // Storage write; suppressed while reset is asserted so reset-cycle requests have no effect.
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register holds the last popped word until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= {WS{1'b0}};
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, watermarks and one-hot operation state.
// Optional sticky overflow/underflow reporting is built when PARAM_FIFO_ERR_EN is defined.
module param_fifo import bus_definitions::*; #(
  parameter int WS       = ws,
  parameter int DEPTH    = depth,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int AS      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [WS-1:0] din,
  input  logic          pop,
  output logic [WS-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AS:0]   count,
`ifdef PARAM_FIFO_ERR_EN
  input  logic          err_clr,
  output logic          overflow,
  output logic          underflow,
`endif
  output logic [3:0]    state
);

  localparam logic [AS:0] DEPTH_C = (AS+1)'(DEPTH);
  localparam logic [AS:0] AF_C    = (AS+1)'(AF_LEVEL);
  localparam logic [AS:0] AE_C    = (AS+1)'(AE_LEVEL);

  logic [AS-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AS-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AS:0]      count_q, count_d;
  fifo_fsm_states_t state_q, state_d;
  logic             push_ok_s, pop_ok_s;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == {(AS+1){1'b0}});
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // A push into a full FIFO is legal only when a pop frees a slot at the same edge.
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop);

  // Next-state, pointer and occupancy logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = IDLE;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AS'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AS'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AS+1)'(1);
      2'b01:   count_d = count_q - (AS+1)'(1);
      default: count_d = count_q;
    endcase
    // A corrupted state register reports idle for one cycle; the datapath is unaffected.
    if (is_onehot4(state_q)) begin
      state_d = op_state(push_ok_s, pop_ok_s);
    end else begin
      state_d = IDLE;
    end
  end

  // State, pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AS{1'b0}};
      rd_ptr_q <= {AS{1'b0}};
      count_q  <= {(AS+1){1'b0}};
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  fifo_regfile #(
    .WS    (WS),
    .DEPTH (DEPTH),
    .AS    (AS)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push_ok_s),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (pop_ok_s),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign count = count_q;
  assign state = state_q;

`ifdef PARAM_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (pop && empty) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo (WS=4, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
module tb_param_fifo;
  import bus_definitions::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [3:0] din = 4'h0;
  logic [3:0] dout;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic [3:0] state;
`ifdef PARAM_FIFO_ERR_EN
  logic       err_clr = 1'b0;
  logic       overflow, underflow;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_fifo #(
    .WS       (4),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .din          (din),
    .pop          (pop),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
`ifdef PARAM_FIFO_ERR_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .state        (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push = 1'($urandom_range(0, 1));
      pop  = 1'($urandom_range(0, 1));
      din  = 4'($urandom_range(0, 15));
      tick();
    end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
    vectors++; if (dout !== 4'h0) begin miscompares++; $display("FAIL reset_dout got %h want 0", dout); end
    vectors++; if (state !== IDLE) begin miscompares++; $display("FAIL reset_state got %b want %b", state, IDLE); end
    vectors++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_marks got ae=%b af=%b want ae=1 af=0", almost_empty, almost_full); end
    rst_n = 1'b1; push = 1'b0; pop = 1'b0; din = 4'h0;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1; din = 4'(i);
      tick();
      vectors++; if (count !== 4'(i) || state !== INSERT) begin miscompares++; $display("FAIL fill_%0d got count=%0d state=%b want count=%0d state=%b", i, count, state, i, INSERT); end
      vectors++; if (almost_full !== (i >= 6) || almost_empty !== (i <= 2)) begin miscompares++; $display("FAIL fill_marks_%0d got af=%b ae=%b", i, almost_full, almost_empty); end
    end
    push = 1'b0;
    vectors++; if (full !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL fill_full got full=%b empty=%b want 1 0", full, empty); end
    for (int i = 1; i <= 8; i++) begin
      pop = 1'b1;
      tick();
      vectors++; if (dout !== 4'(i) || state !== REMOVE || count !== 4'(8 - i)) begin miscompares++; $display("FAIL drain_%0d got dout=%h state=%b count=%0d want dout=%h count=%0d", i, dout, state, count, i, 8 - i); end
    end
    vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL drain_empty got empty=%b full=%b want 1 0", empty, full); end
    tick();
    pop = 1'b0;
    vectors++; if (state !== IDLE || dout !== 4'h8 || count !== 4'd0) begin miscompares++; $display("FAIL pop_on_empty got state=%b dout=%h count=%0d want idle 8 0", state, dout, count); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1; din = 4'(i);
      tick();
    end
    push = 1'b1; pop = 1'b1; din = 4'hA;
    tick();
    push = 1'b0; pop = 1'b0;
    vectors++; if (state !== INSERT_REMOVE || count !== 4'd8 || dout !== 4'h1) begin miscompares++; $display("FAIL full_push_pop got state=%b count=%0d dout=%h want %b 8 1", state, count, dout, INSERT_REMOVE); end
    for (int i = 2; i <= 9; i++) begin
      pop = 1'b1;
      tick();
      vectors++; if (dout !== ((i == 9) ? 4'hA : 4'(i))) begin miscompares++; $display("FAIL full_drain_%0d got dout=%h", i, dout); end
    end
    pop = 1'b0;
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL full_drain_count got %0d want 0", count); end
  endtask

  task automatic test_empty_push_pop();
    push = 1'b1; pop = 1'b1; din = 4'h5;
    tick();
    push = 1'b0; pop = 1'b0;
    vectors++; if (state !== INSERT || count !== 4'd1 || dout !== 4'hA) begin miscompares++; $display("FAIL empty_push_pop got state=%b count=%0d dout=%h want %b 1 a", state, count, dout, INSERT); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    vectors++; if (dout !== 4'h5 || state !== REMOVE || count !== 4'd0) begin miscompares++; $display("FAIL empty_then_pop got dout=%h state=%b count=%0d want 5 remove 0", dout, state, count); end
  endtask

  task automatic test_wrap_watermarks();
    logic [3:0] q[$];
    logic [3:0] expd;
    logic       p, r, push_m, pop_m;
    int         sent = 0;
    int         got = 0;
    for (int i = 0; i < 120 && got < 20; i++) begin
      p = (sent < 20) && ((i % 4) != 3);
      r = ((i >= 6) && ((i % 2) == 1)) || (sent >= 20);
      pop_m  = r && (q.size() > 0);
      push_m = p && ((q.size() < 8) || r);
      push = p; pop = r; din = 4'(sent * 5 + 3);
      expd = 4'h0;
      if (pop_m) expd = q.pop_front();
      if (push_m) begin q.push_back(din); sent++; end
      tick();
      vectors++; if (count !== 4'(q.size())) begin miscompares++; $display("FAIL wrap_count_%0d got %0d want %0d", i, count, q.size()); end
      vectors++; if (almost_full !== (q.size() >= 6) || almost_empty !== (q.size() <= 2)) begin miscompares++; $display("FAIL wrap_marks_%0d got af=%b ae=%b count=%0d", i, almost_full, almost_empty, q.size()); end
      if (pop_m) begin
        got++;
        vectors++; if (dout !== expd) begin miscompares++; $display("FAIL wrap_data_%0d got %h want %h", i, dout, expd); end
      end
    end
    push = 1'b0; pop = 1'b0;
    vectors++; if (got != 20) begin miscompares++; $display("FAIL wrap_budget got %0d words want 20", got); end
  endtask

`ifdef PARAM_FIFO_ERR_EN
  task automatic test_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL err_clear0 got ovf=%b unf=%b want 0 0", overflow, underflow); end
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; din = 4'(i);
      tick();
    end
    tick();
    push = 1'b0;
    vectors++; if (overflow !== 1'b1 || count !== 4'd8 || state !== IDLE) begin miscompares++; $display("FAIL err_overflow got ovf=%b count=%0d state=%b want 1 8 idle", overflow, count, state); end
    tick();
    vectors++; if (overflow !== 1'b1 || underflow !== 1'b0) begin miscompares++; $display("FAIL err_sticky got ovf=%b unf=%b want 1 0", overflow, underflow); end
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      tick();
    end
    tick();
    pop = 1'b0;
    vectors++; if (underflow !== 1'b1 || count !== 4'd0) begin miscompares++; $display("FAIL err_underflow got unf=%b count=%0d want 1 0", underflow, count); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL err_clear got ovf=%b unf=%b want 0 0", overflow, underflow); end
    err_clr = 1'b1; pop = 1'b1;
    tick();
    err_clr = 1'b0; pop = 1'b0;
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL err_set_wins got unf=%b want 1", underflow); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap_watermarks();
`ifdef PARAM_FIFO_ERR_EN
    test_errors();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
